regfile_bus: RTL

Parametrised register bank with an integrated bus driver for the multi-cycle processor datapath. It holds NREGS general registers of WIDTH bits and selects exactly one source onto `buswires` from the registers, DIN or G using one-hot `_out` controls, and loads selected registers from the bus on the clock edge. The top register doubles as the program counter, with a dedicated increment. A sticky flag records any multi-driver cycle.

---
 rtl/regfile_bus.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_bus.sv
// Register bank with one-hot bus driver, PC increment and sticky conflict flag.
// Optional macro REGFILE_BUS_HOLD_EN: idle bus repeats the last driven value.
module regfile_bus #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREGS-1:0] reg_out,
    input  logic             din_out,
    input  logic             g_out,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] g,
    input  logic [NREGS-1:0] reg_in,
    input  logic             pc_inc,
    input  logic             conflict_clr,
    input  logic [SELW-1:0]  dbg_sel,
    output logic [WIDTH-1:0] buswires,
    output logic [WIDTH-1:0] dbg_data,
    output logic             bus_conflict
);

    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NREGS+1:0] D_ONE = {{(NREGS+1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] idle_val;
    logic [NREGS+1:0] drv;
    logic             active;
    logic             conflict;

    assign drv      = {g_out, din_out, reg_out};
    assign active   = |drv;
    // Two or more drivers iff clearing the lowest set bit leaves something.
    assign conflict = (drv & (drv - D_ONE)) != '0;

`ifdef REGFILE_BUS_HOLD_EN
    logic [WIDTH-1:0] bus_q;

    assign idle_val = bus_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_q <= '0;
        end else if (active) begin
            bus_q <= buswires;
        end
    end
`else
    assign idle_val = '0;
`endif

    // Walk from lowest priority upward so the highest-priority source wins.
    always_comb begin
        src_val = '0;
        if (g_out) begin
            src_val = g;
        end
        if (din_out) begin
            src_val = din;
        end
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (reg_out[i]) begin
                src_val = regs[i];
            end
        end
    end

    assign buswires = active ? src_val : idle_val;
    assign dbg_data = regs[dbg_sel];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i]) begin
                    regs[i] <= buswires;
                end else if (i == NREGS - 1 && pc_inc) begin
                    regs[i] <= regs[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_conflict <= 1'b0;
        end else if (conflict) begin
            bus_conflict <= 1'b1;
        end else if (conflict_clr) begin
            bus_conflict <= 1'b0;
        end
    end

endmodule
